// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel-rate divider, x/y counters, sync decode and a
// registered output stage that keeps blanked colour and sync aligned on the pins.
module vga_timing_gen #(
   parameter int CLK_DIV         = 2,
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       pixel_on,
   output logic       pix_tick,
   output logic       frame_start,
   input  logic       red_in,
   input  logic       green_in,
   input  logic       blue_in,
   output logic       vga_r,
   output logic       vga_g,
   output logic       vga_b,
   output logic       vga_hs,
   output logic       vga_vs
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_STOP  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic       SYNC_OFF = (SYNC_ACTIVE_LOW != 0);
   localparam logic       SYNC_ON  = ~SYNC_OFF;

   logic [3:0] div_reg, div_next;
   logic [9:0] x_reg, x_next;
   logic [9:0] y_reg, y_next;
   logic       hs_reg, vs_reg;
   logic       hs_raw, vs_raw;
   logic       tick_int;
   logic [2:0] rgb_in;
   logic [2:0] rgb_reg;

   // Internal tick drives the state; the port copy is also forced low while in reset,
   // which matters for CLK_DIV=1 where the divider compare is always true.
   assign tick_int    = (div_reg == DIV_LAST);
   assign pix_tick    = tick_int & rst_n;
   assign x           = x_reg;
   assign y           = y_reg;
   assign pixel_on    = (x_reg < H_VIS) && (y_reg < V_VIS);
   assign frame_start = pix_tick && (x_reg == H_LAST) && (y_reg == V_LAST);
   assign hs_raw      = ((x_reg >= HS_START) && (x_reg < HS_STOP)) ? SYNC_ON : SYNC_OFF;
   assign vs_raw      = ((y_reg >= VS_START) && (y_reg < VS_STOP)) ? SYNC_ON : SYNC_OFF;

   always_comb begin
      div_next = div_reg + 4'd1;
      x_next   = x_reg;
      y_next   = y_reg;
      if (tick_int) begin
         div_next = 4'd0;
         if (x_reg == H_LAST) begin
            x_next = 10'd0;
            y_next = (y_reg == V_LAST) ? 10'd0 : y_reg + 10'd1;
         end else begin
            x_next = x_reg + 10'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg <= 4'd0;
         x_reg   <= 10'd0;
         y_reg   <= 10'd0;
         hs_reg  <= SYNC_OFF;
         vs_reg  <= SYNC_OFF;
      end else begin
         div_reg <= div_next;
         x_reg   <= x_next;
         y_reg   <= y_next;
         if (tick_int) begin
            hs_reg <= hs_raw;
            vs_reg <= vs_raw;
         end
      end
   end

   // Colour is blanked against the same x/y that the sync stage samples, so both
   // leave the block exactly one pixel behind the counters.
   assign rgb_in = {red_in, green_in, blue_in};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_colour
         logic chan_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               chan_reg <= 1'b0;
            end else if (tick_int) begin
               chan_reg <= rgb_in[gi] & pixel_on;
            end
         end
         assign rgb_reg[gi] = chan_reg;
      end
   endgenerate

   assign vga_r  = rgb_reg[2];
   assign vga_g  = rgb_reg[1];
   assign vga_b  = rgb_reg[0];
   assign vga_hs = hs_reg;
   assign vga_vs = vs_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance (CLK_DIV=2) and a shrunken-raster
// instance (CLK_DIV=1) checked every cycle against a position-arithmetic model.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int mode = 0;                 // 0 random table, 1 all ones, 2 red=(x==100)
   logic [2:0] lut [256];
   int unsigned checks = 0;
   int unsigned passed = 0;
   int cyc;

   logic [9:0] x_a, y_a, x_b, y_b;
   logic on_a, tick_a, fs_a, r_a, g_a, b_a, hs_a, vs_a;
   logic on_b, tick_b, fs_b, r_b, g_b, b_b, hs_b, vs_b;
   logic [2:0] rgbin_a, rgbin_b;
   logic [7:0] idx_a, idx_b;

   vga_timing_gen u_full (
      .clk(clk), .rst_n(rst_n), .x(x_a), .y(y_a), .pixel_on(on_a), .pix_tick(tick_a),
      .frame_start(fs_a), .red_in(rgbin_a[2]), .green_in(rgbin_a[1]), .blue_in(rgbin_a[0]),
      .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a));

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_ACTIVE_LOW(1)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .x(x_b), .y(y_b), .pixel_on(on_b), .pix_tick(tick_b),
      .frame_start(fs_b), .red_in(rgbin_b[2]), .green_in(rgbin_b[1]), .blue_in(rgbin_b[0]),
      .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b));

   // Pattern source: combinational from each instance's own coordinates.
   assign idx_a = 8'(int'(x_a) * 7 + int'(y_a) * 13);
   assign idx_b = 8'(int'(x_b) * 7 + int'(y_b) * 13);
   always_comb begin
      rgbin_a = lut[idx_a];
      rgbin_b = lut[idx_b];
      if (mode == 1) begin
         rgbin_a = 3'b111;
         rgbin_b = 3'b111;
      end else if (mode == 2) begin
         rgbin_a = {x_a == 10'd100, 2'b00};
         rgbin_b = {x_b == 10'd100, 2'b00};
      end
   end

   function automatic logic [2:0] col(input int m, input int cx, input int cy);
      if (m == 1) return 3'b111;
      if (m == 2) return {cx == 100, 2'b00};
      return lut[(cx * 7 + cy * 13) % 256];
   endfunction

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       on;
      logic       tick;
      logic       fs;
      logic       hs;
      logic       vs;
   } exp_t;

   // Everything follows from the number of ticks since release: position = ticks mod
   // frame size, and the registered sync reflects the previous position.
   function automatic exp_t model(input logic rn, input int c, input int d,
                                  input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb);
      exp_t e;
      int ht, vt, ticks, pos, prev, px, py;
      ht    = hv + hf + hsw + hb;
      vt    = vv + vf + vsw + vb;
      ticks = rn ? c / d : 0;
      pos   = ticks % (ht * vt);
      e.x   = 10'(pos % ht);
      e.y   = 10'(pos / ht);
      e.on  = ((pos % ht) < hv) && ((pos / ht) < vv);
      e.tick = rn && ((c % d) == d - 1);
      e.fs  = e.tick && (pos == ht * vt - 1);
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      if (ticks != 0) begin
         prev = (pos + ht * vt - 1) % (ht * vt);
         px   = prev % ht;
         py   = prev / ht;
         e.hs = !(px >= hv + hf && px < hv + hf + hsw);
         e.vs = !(py >= vv + vf && py < vv + vf + vsw);
      end
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, req);
   endtask

   task automatic check_one(input string tag, input exp_t e,
                            input logic [9:0] dx, input logic [9:0] dy,
                            input logic don, input logic dtick, input logic dfs,
                            input logic dhs, input logic dvs,
                            input logic [2:0] drgb, input logic [2:0] ergb);
      checks++;
      if ({dx, dy, don, dtick, dfs, dhs, dvs, drgb} === {e, ergb}) passed++;
      else $display("FAIL %s cyc=%0d: got x=%0d y=%0d on=%b tick=%b fs=%b hs=%b vs=%b rgb=%b, expected x=%0d y=%0d on=%b tick=%b fs=%b hs=%b vs=%b rgb=%b",
                    tag, cyc, dx, dy, don, dtick, dfs, dhs, dvs, drgb,
                    e.x, e.y, e.on, e.tick, e.fs, e.hs, e.vs, ergb);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   exp_t ea, eb;
   logic [2:0] erg_a = 3'b000;
   logic [2:0] erg_b = 3'b000;

   // Per-cycle compare; the colour expected after a tick is the blanked pattern value
   // at the position the model was on when that tick happened.
   always @(negedge clk) begin
      ea = model(rst_n, cyc, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(rst_n, cyc, 1, 16, 2, 3, 4, 8, 2, 2, 3);
      if (!rst_n) begin
         erg_a = 3'b000;
         erg_b = 3'b000;
      end
      check_one("dut_full", ea, x_a, y_a, on_a, tick_a, fs_a, hs_a, vs_a, {r_a, g_a, b_a}, erg_a);
      check_one("dut_small", eb, x_b, y_b, on_b, tick_b, fs_b, hs_b, vs_b, {r_b, g_b, b_b}, erg_b);
      if (rst_n && ea.tick) erg_a = col(mode, int'(ea.x), int'(ea.y)) & {3{ea.on}};
      if (rst_n && eb.tick) erg_b = col(mode, int'(eb.x), int'(eb.y)) & {3{eb.on}};
   end

   task automatic wait_a(input int tx, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (tick_a && x_a == 10'(tx) && y_a < 10'd480) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      bit ok;
      int low, n, y0, fsn, vsl;
      for (int i = 0; i < 256; i++) lut[i] = 3'($urandom);
      repeat ($urandom_range(3, 7)) @(posedge clk);
      #3 rst_n = 1'b1;

      // First tick lands on the second clock after release with CLK_DIV=2.
      @(negedge clk);
      chk("tick_before_first_edge", int'(tick_a), 0);
      chk("div1_tick_immediate", int'(tick_b), 1);
      @(negedge clk);
      chk("first_tick", int'(tick_a), 1);
      chk("x_before_first_advance", int'(x_a), 0);
      @(negedge clk);
      chk("x_after_first_advance", int'(x_a), 1);

      // Hsync: one pixel behind x, exactly 96 pixels wide.
      wait_a(656, ok);
      chk("seen_x656", int'(ok), 1);
      chk("hs_high_at_x656", int'(hs_a), 1);
      @(negedge clk);
      chk("hs_low_at_x657", int'(hs_a), 0);
      low = 0;
      n = 0;
      for (int g = 0; g < 4000 && n < 800; g++) begin
         if (tick_a) begin
            n++;
            if (!hs_a) low++;
         end
         @(negedge clk);
      end
      chk("hs_low_pixels", low, 96);

      // Line wrap: x 799->0 and y increments on the same edge.
      wait_a(799, ok);
      chk("seen_x799", int'(ok), 1);
      y0 = int'(y_a);
      @(negedge clk);
      chk("x_wrap", int'(x_a), 0);
      chk("y_step", int'(y_a), y0 + 1);

      // Blanking edge with colour tied high.
      @(posedge clk);
      #3 mode = 1;
      wait_a(639, ok);
      chk("on_at_639", int'(on_a), 1);
      wait_a(640, ok);
      chk("on_at_640", int'(on_a), 0);
      chk("r_at_640", int'(r_a), 1);
      wait_a(641, ok);
      chk("r_at_641", int'(r_a), 0);

      // Alignment: red only at x==100 shows up one pixel later for one pixel.
      @(posedge clk);
      #3 mode = 2;
      wait_a(100, ok);
      chk("r_at_100", int'(r_a), 0);
      wait_a(101, ok);
      chk("r_at_101", int'(r_a), 1);
      wait_a(102, ok);
      chk("r_at_102", int'(r_a), 0);

      // Reset mid-line takes effect before the next clock edge.
      @(posedge clk);
      #3 mode = 0;
      wait_a(300, ok);
      chk("seen_x300", int'(ok), 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_x", int'(x_a), 0);
      chk("rst_y", int'(y_a), 0);
      chk("rst_hs", int'(hs_a), 1);
      chk("rst_vs", int'(vs_a), 1);
      chk("rst_rgb", int'({r_a, g_a, b_a}), 0);
      chk("rst_tick_div1", int'(tick_b), 0);

      // Small raster: three frames give three frame_start pulses and 2 lines of vsync each.
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      fsn = 0;
      vsl = 0;
      for (int i = 0; i < 1125; i++) begin
         @(negedge clk);
         if (fs_b) fsn++;
         if (tick_b && !vs_b) vsl++;
      end
      chk("frame_start_count", fsn, 3);
      chk("vs_low_pixels", vsl, 150);

      // Randomised pattern changes and reset pulses, covered by the per-cycle compare.
      for (int k = 0; k < 25; k++) begin
         repeat ($urandom_range(40, 500)) @(posedge clk);
         #3 mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 5) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #3 rst_n = 1'b1;
         end
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
